// File: rtl/axi_slave_burst_mem.sv
// AXI burst slave backed by a word-wide register memory.
// Independent read and write FSMs; FIXED/INCR/WRAP bursts with per-beat range checking.
module axi_slave_burst_mem #(
    parameter int unsigned                  AXI_ID_WIDTH   = 4,
    parameter int unsigned                  AXI_DATA_WIDTH = 32,
    parameter int unsigned                  AXI_ADDR_WIDTH = 32,
    parameter int unsigned                  MEM_DEPTH      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0]    BASE_ADDR      = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXI_ID_WIDTH-1:0]       AXI_slave_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]     AXI_slave_awaddr,
    input  logic [7:0]                    AXI_slave_awlen,
    input  logic [1:0]                    AXI_slave_awburst,
    input  logic                          AXI_slave_awvalid,
    output logic                          AXI_slave_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     AXI_slave_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   AXI_slave_wstrb,
    input  logic                          AXI_slave_wlast,
    input  logic                          AXI_slave_wvalid,
    output logic                          AXI_slave_wready,
    output logic [AXI_ID_WIDTH-1:0]       AXI_slave_bid,
    output logic [1:0]                    AXI_slave_bresp,
    output logic                          AXI_slave_bvalid,
    input  logic                          AXI_slave_bready,
    input  logic [AXI_ID_WIDTH-1:0]       AXI_slave_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]     AXI_slave_araddr,
    input  logic [7:0]                    AXI_slave_arlen,
    input  logic [1:0]                    AXI_slave_arburst,
    input  logic                          AXI_slave_arvalid,
    output logic                          AXI_slave_arready,
    output logic [AXI_ID_WIDTH-1:0]       AXI_slave_rid,
    output logic [AXI_DATA_WIDTH-1:0]     AXI_slave_rdata,
    output logic [1:0]                    AXI_slave_rresp,
    output logic                          AXI_slave_rlast,
    output logic                          AXI_slave_rvalid,
    input  logic                          AXI_slave_rready
);

    localparam int unsigned AW     = AXI_ADDR_WIDTH;
    localparam int unsigned DW     = AXI_DATA_WIDTH;
    localparam int unsigned STRB_W = DW / 8;
    localparam int unsigned OFF    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic in_range(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> OFF) < AW'(MEM_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = (a - BASE_ADDR) >> OFF;
        return IDX_W'(off);
    endfunction

    // WRAP keeps the upper address bits and wraps the low bits inside a (len+1)-word block.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                                input logic [7:0]    len,
                                                input logic [1:0]    burst);
        logic [AW-1:0] inc;
        logic [AW-1:0] mask;
        inc  = a + AW'(STRB_W);
        mask = (AW'(len) << OFF) | AW'(STRB_W - 1);
        if (burst == BURST_FIXED) begin
            return a;
        end else if ((burst == BURST_WRAP) &&
                     ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))) begin
            return (a & ~mask) | (inc & mask);
        end else begin
            return inc;
        end
    endfunction

    logic [DW-1:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_t         w_state, w_state_n;
    logic [AW-1:0]    w_addr, w_addr_n;
    logic [7:0]       w_len, w_len_n;
    logic [1:0]       w_burst, w_burst_n;
    logic [7:0]       w_cnt, w_cnt_n;
    logic             w_dec, w_dec_n;
    logic             w_slv, w_slv_n;
    logic             awready_n, wready_n, bvalid_n;
    logic [1:0]       bresp_n;
    logic [AXI_ID_WIDTH-1:0] bid_n;
    logic             mem_we;
    logic             w_inr;
    logic [IDX_W-1:0] w_idx;
    logic [DW-1:0]    wbit_mask;

    assign w_inr = in_range(w_addr);
    assign w_idx = word_idx(w_addr);

    for (genvar g = 0; g < STRB_W; g++) begin : g_wmask
        assign wbit_mask[g*8 +: 8] = {8{AXI_slave_wstrb[g]}};
    end

    always_comb begin
        w_state_n = w_state;
        w_addr_n  = w_addr;
        w_len_n   = w_len;
        w_burst_n = w_burst;
        w_cnt_n   = w_cnt;
        w_dec_n   = w_dec;
        w_slv_n   = w_slv;
        bresp_n   = AXI_slave_bresp;
        bid_n     = AXI_slave_bid;
        mem_we    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (AXI_slave_awvalid && AXI_slave_awready) begin
                    bid_n     = AXI_slave_awid;
                    w_addr_n  = AXI_slave_awaddr;
                    w_len_n   = AXI_slave_awlen;
                    w_burst_n = AXI_slave_awburst;
                    w_cnt_n   = 8'd0;
                    w_dec_n   = 1'b0;
                    w_slv_n   = 1'b0;
                    w_state_n = W_DATA;
                end
            end
            W_DATA: begin
                if (AXI_slave_wvalid && AXI_slave_wready) begin
                    mem_we  = w_inr;
                    w_dec_n = w_dec | ~w_inr;
                    w_slv_n = w_slv | (w_burst == BURST_RSVD) |
                              (AXI_slave_wlast != (w_cnt == w_len));
                    // Burst length comes from awlen; wlast only feeds the error flag.
                    if (w_cnt == w_len) begin
                        w_state_n = W_RESP;
                        bresp_n   = w_dec_n ? RESP_DECERR :
                                    (w_slv_n ? RESP_SLVERR : RESP_OKAY);
                    end else begin
                        w_cnt_n  = w_cnt + 8'd1;
                        w_addr_n = next_addr(w_addr, w_len, w_burst);
                    end
                end
            end
            W_RESP: begin
                if (AXI_slave_bvalid && AXI_slave_bready) begin
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
        awready_n = (w_state_n == W_IDLE);
        wready_n  = (w_state_n == W_DATA);
        bvalid_n  = (w_state_n == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state           <= W_IDLE;
            w_addr            <= '0;
            w_len             <= '0;
            w_burst           <= '0;
            w_cnt             <= '0;
            w_dec             <= 1'b0;
            w_slv             <= 1'b0;
            AXI_slave_awready <= 1'b0;
            AXI_slave_wready  <= 1'b0;
            AXI_slave_bvalid  <= 1'b0;
            AXI_slave_bresp   <= '0;
            AXI_slave_bid     <= '0;
        end else begin
            w_state           <= w_state_n;
            w_addr            <= w_addr_n;
            w_len             <= w_len_n;
            w_burst           <= w_burst_n;
            w_cnt             <= w_cnt_n;
            w_dec             <= w_dec_n;
            w_slv             <= w_slv_n;
            AXI_slave_awready <= awready_n;
            AXI_slave_wready  <= wready_n;
            AXI_slave_bvalid  <= bvalid_n;
            AXI_slave_bresp   <= bresp_n;
            AXI_slave_bid     <= bid_n;
        end
    end

    // Storage; reads sample the old contents on the cycle a word is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else if (mem_we) begin
            mem[w_idx] <= (mem[w_idx] & ~wbit_mask) | (AXI_slave_wdata & wbit_mask);
        end
    end

    // ---------------- read channel ----------------
    r_state_t         r_state, r_state_n;
    logic [AW-1:0]    r_addr, r_addr_n;
    logic [7:0]       r_len, r_len_n;
    logic [1:0]       r_burst, r_burst_n;
    logic [7:0]       r_cnt, r_cnt_n;
    logic             arready_n, rvalid_n, rlast_n;
    logic [1:0]       rresp_n;
    logic [DW-1:0]    rdata_n;
    logic [AXI_ID_WIDTH-1:0] rid_n;
    logic [AW-1:0]    r_fetch_addr;
    logic [1:0]       r_fetch_burst;
    logic             r_fetch_inr;
    logic [DW-1:0]    r_fetch_data;
    logic [1:0]       r_fetch_resp;

    // Address of the beat to be loaded into the R registers at the next edge.
    always_comb begin
        if (r_state == R_IDLE) begin
            r_fetch_addr  = AXI_slave_araddr;
            r_fetch_burst = AXI_slave_arburst;
        end else begin
            r_fetch_addr  = next_addr(r_addr, r_len, r_burst);
            r_fetch_burst = r_burst;
        end
    end

    assign r_fetch_inr  = in_range(r_fetch_addr);
    assign r_fetch_data = r_fetch_inr ? mem[word_idx(r_fetch_addr)] : '0;
    assign r_fetch_resp = !r_fetch_inr ? RESP_DECERR :
                          ((r_fetch_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY);

    always_comb begin
        r_state_n = r_state;
        r_addr_n  = r_addr;
        r_len_n   = r_len;
        r_burst_n = r_burst;
        r_cnt_n   = r_cnt;
        rid_n     = AXI_slave_rid;
        rdata_n   = AXI_slave_rdata;
        rresp_n   = AXI_slave_rresp;
        rlast_n   = AXI_slave_rlast;
        case (r_state)
            R_IDLE: begin
                if (AXI_slave_arvalid && AXI_slave_arready) begin
                    rid_n     = AXI_slave_arid;
                    r_addr_n  = r_fetch_addr;
                    r_len_n   = AXI_slave_arlen;
                    r_burst_n = AXI_slave_arburst;
                    r_cnt_n   = 8'd0;
                    rdata_n   = r_fetch_data;
                    rresp_n   = r_fetch_resp;
                    rlast_n   = (AXI_slave_arlen == 8'd0);
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (AXI_slave_rvalid && AXI_slave_rready) begin
                    if (r_cnt == r_len) begin
                        rlast_n   = 1'b0;
                        r_state_n = R_IDLE;
                    end else begin
                        r_cnt_n  = r_cnt + 8'd1;
                        r_addr_n = r_fetch_addr;
                        rdata_n  = r_fetch_data;
                        rresp_n  = r_fetch_resp;
                        rlast_n  = ((r_cnt + 8'd1) == r_len);
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        arready_n = (r_state_n == R_IDLE);
        rvalid_n  = (r_state_n == R_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= R_IDLE;
            r_addr            <= '0;
            r_len             <= '0;
            r_burst           <= '0;
            r_cnt             <= '0;
            AXI_slave_arready <= 1'b0;
            AXI_slave_rvalid  <= 1'b0;
            AXI_slave_rlast   <= 1'b0;
            AXI_slave_rresp   <= '0;
            AXI_slave_rdata   <= '0;
            AXI_slave_rid     <= '0;
        end else begin
            r_state           <= r_state_n;
            r_addr            <= r_addr_n;
            r_len             <= r_len_n;
            r_burst           <= r_burst_n;
            r_cnt             <= r_cnt_n;
            AXI_slave_arready <= arready_n;
            AXI_slave_rvalid  <= rvalid_n;
            AXI_slave_rlast   <= rlast_n;
            AXI_slave_rresp   <= rresp_n;
            AXI_slave_rdata   <= rdata_n;
            AXI_slave_rid     <= rid_n;
        end
    end

endmodule
